// File: rtl/symbol_lock_ctrl.sv
// symbol_lock_ctrl
// Receive-side symbol-lock controller: requests deserializer bit-slips until
// commas appear, declares lock after a run of commas, and drops lock when
// decode errors become excessive.
//
// Optional feature macro: SYMLOCK_SLIP_EN
//   defined   -> an UNLOCKED search timeout pulses slip_req and enters SLIP_WAIT
//   undefined -> slip_req is tied low, SLIP_WAIT is unreachable, and a search
//                timeout only restarts the search counter (external aligner)
module symbol_lock_ctrl #(
  parameter int LOCK_COMMAS    = 3,
  parameter int ERR_LIMIT      = 4,
  parameter int GOOD_RUN       = 4,
  parameter int SEARCH_TIMEOUT = 64,
  parameter int SLIP_HOLDOFF   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_en,
  input  logic       comma_in,
  input  logic       decode_err,
  output logic       slip_req,
  output logic       locked,
  output logic       rx_valid,
  output logic [2:0] lock_state
);

  // Counter widths hold parameter+1 so no counter can wrap.
  localparam int SW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int CW = $clog2(LOCK_COMMAS + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam int GW = $clog2(GOOD_RUN + 1);
  localparam int HW = $clog2(SLIP_HOLDOFF + 1);

  localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_TIMEOUT - 1);
  localparam logic [SW-1:0] SEARCH_ONE  = SW'(1);
  localparam logic [CW-1:0] COMMA_LAST  = CW'(LOCK_COMMAS - 1);
  localparam logic [CW-1:0] COMMA_ONE   = CW'(1);
  localparam logic [EW-1:0] ERR_LAST    = EW'(ERR_LIMIT - 1);
  localparam logic [EW-1:0] ERR_ONE     = EW'(1);
  localparam logic [GW-1:0] GOOD_LAST   = GW'(GOOD_RUN - 1);
  localparam logic [GW-1:0] GOOD_ONE    = GW'(1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(SLIP_HOLDOFF - 1);
  localparam logic [HW-1:0] HOLD_ONE    = HW'(1);

  typedef enum logic [2:0] {
    ST_UNLOCKED  = 3'd0,
    ST_SLIP_WAIT = 3'd1,
    ST_ACQUIRE   = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_CHECK     = 3'd4
  } state_t;

  state_t        state_q,  state_d;
  logic [SW-1:0] search_q, search_d;
  logic [CW-1:0] comma_q,  comma_d;
  logic [EW-1:0] err_q,    err_d;
  logic [GW-1:0] good_q,   good_d;
  logic [HW-1:0] hold_q,   hold_d;
  logic          slip_set_s;

  logic          slip_req_q,   slip_req_d;
  logic          locked_q,     locked_d;
  logic          rx_valid_q,   rx_valid_d;
  logic [2:0]    lock_state_q, lock_state_d;

  // A comma only counts when the symbol also decoded cleanly.
  logic comma_ok_s;
  assign comma_ok_s = comma_in & ~decode_err;

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_UNLOCKED;
      search_q     <= {SW{1'b0}};
      comma_q      <= {CW{1'b0}};
      err_q        <= {EW{1'b0}};
      good_q       <= {GW{1'b0}};
      hold_q       <= {HW{1'b0}};
      slip_req_q   <= 1'b0;
      locked_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      lock_state_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      search_q     <= search_d;
      comma_q      <= comma_d;
      err_q        <= err_d;
      good_q       <= good_d;
      hold_q       <= hold_d;
      slip_req_q   <= slip_req_d;
      locked_q     <= locked_d;
      rx_valid_q   <= rx_valid_d;
      lock_state_q <= lock_state_d;
    end
  end

  // Next-state and counter update; only a qualified symbol advances anything.
  always_comb begin
    state_d    = state_q;
    search_d   = search_q;
    comma_d    = comma_q;
    err_d      = err_q;
    good_d     = good_q;
    hold_d     = hold_q;
    slip_set_s = 1'b0;
    if (sym_en) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (comma_ok_s) begin
            search_d = {SW{1'b0}};
            if (COMMA_LAST == {CW{1'b0}}) begin
              state_d = ST_LOCKED;
              comma_d = {CW{1'b0}};
            end else begin
              state_d = ST_ACQUIRE;
              comma_d = COMMA_ONE;
            end
          end else if (search_q >= SEARCH_LAST) begin
            search_d = {SW{1'b0}};
`ifdef SYMLOCK_SLIP_EN
            slip_set_s = 1'b1;
            state_d    = ST_SLIP_WAIT;
            hold_d     = {HW{1'b0}};
`else
            state_d    = ST_UNLOCKED;
`endif
          end else begin
            search_d = search_q + SEARCH_ONE;
          end
        end
        ST_SLIP_WAIT: begin
          // Inputs are ignored while the deserializer realigns.
          if (hold_q >= HOLD_LAST) begin
            state_d  = ST_UNLOCKED;
            hold_d   = {HW{1'b0}};
            search_d = {SW{1'b0}};
          end else begin
            hold_d = hold_q + HOLD_ONE;
          end
        end
        ST_ACQUIRE: begin
          if (decode_err) begin
            state_d  = ST_UNLOCKED;
            search_d = {SW{1'b0}};
            comma_d  = {CW{1'b0}};
          end else if (comma_in) begin
            search_d = {SW{1'b0}};
            if (comma_q >= COMMA_LAST) begin
              state_d = ST_LOCKED;
              comma_d = {CW{1'b0}};
            end else begin
              comma_d = comma_q + COMMA_ONE;
            end
          end else if (search_q >= SEARCH_LAST) begin
            state_d  = ST_UNLOCKED;
            search_d = {SW{1'b0}};
            comma_d  = {CW{1'b0}};
          end else begin
            search_d = search_q + SEARCH_ONE;
          end
        end
        ST_LOCKED: begin
          if (decode_err) begin
            state_d = ST_CHECK;
            err_d   = ERR_ONE;
            good_d  = {GW{1'b0}};
          end else begin
            state_d = ST_LOCKED;
          end
        end
        ST_CHECK: begin
          if (decode_err) begin
            good_d = {GW{1'b0}};
            if (err_q >= ERR_LAST) begin
              state_d  = ST_UNLOCKED;
              err_d    = {EW{1'b0}};
              search_d = {SW{1'b0}};
              comma_d  = {CW{1'b0}};
              hold_d   = {HW{1'b0}};
            end else begin
              err_d = err_q + ERR_ONE;
            end
          end else if (good_q >= GOOD_LAST) begin
            good_d = {GW{1'b0}};
            if (err_q <= ERR_ONE) begin
              state_d = ST_LOCKED;
              err_d   = {EW{1'b0}};
            end else begin
              err_d = err_q - ERR_ONE;
            end
          end else begin
            good_d = good_q + GOOD_ONE;
          end
        end
        default: begin
          state_d  = ST_UNLOCKED;
          search_d = {SW{1'b0}};
          comma_d  = {CW{1'b0}};
          err_d    = {EW{1'b0}};
          good_d   = {GW{1'b0}};
          hold_d   = {HW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output next values; slip_req falls unconditionally after its single pulse.
  always_comb begin
    slip_req_d   = slip_set_s;
    lock_state_d = state_d;
    rx_valid_d   = sym_en & locked_q;
    if ((state_d == ST_LOCKED) || (state_d == ST_CHECK)) begin
      locked_d = 1'b1;
    end else begin
      locked_d = 1'b0;
    end
  end

  assign slip_req   = slip_req_q;
  assign locked     = locked_q;
  assign rx_valid   = rx_valid_q;
  assign lock_state = lock_state_q;

endmodule
